// File: rtl/raster_counter_pkg.sv
// rtl/raster_counter_pkg.sv - video timing presets and axis total helper for raster_counter
package raster_counter_pkg;

    localparam int P1080_H_ACTIVE = 1920;
    localparam int P1080_H_FP     = 88;
    localparam int P1080_H_SYNC   = 44;
    localparam int P1080_H_BP     = 148;
    localparam int P1080_V_ACTIVE = 1080;
    localparam int P1080_V_FP     = 4;
    localparam int P1080_V_SYNC   = 5;
    localparam int P1080_V_BP     = 36;

    localparam int P720_H_ACTIVE  = 1280;
    localparam int P720_H_FP      = 110;
    localparam int P720_H_SYNC    = 40;
    localparam int P720_H_BP      = 220;
    localparam int P720_V_ACTIVE  = 720;
    localparam int P720_V_FP      = 5;
    localparam int P720_V_SYNC    = 5;
    localparam int P720_V_BP      = 20;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int axis_sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int axis_sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/raster_counter_if.sv
// rtl/raster_counter_if.sv - raster position/sync bundle; irq ports exist only with RASTER_LINE_IRQ_EN
interface raster_counter_if #(
    parameter int XW = 12,
    parameter int YW = 11
);
    logic          pix_en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;
`ifdef RASTER_LINE_IRQ_EN
    logic [YW-1:0] irq_line;
    logic          line_irq;
`endif

    modport master (
        input  pix_en,
`ifdef RASTER_LINE_IRQ_EN
        input  irq_line,
        output line_irq,
`endif
        output x, y, active, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output pix_en,
`ifdef RASTER_LINE_IRQ_EN
        output irq_line,
        input  line_irq,
`endif
        input  x, y, active, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/raster_counter_axis.sv
// rtl/raster_counter_axis.sv - axis_counter: one wrapping raster axis with registered active/sync decode
module axis_counter #(
    parameter int   TOTAL  = 8,
    parameter int   ACTIVE = 4,
    parameter int   FP     = 1,
    parameter int   SYNC   = 2,
    parameter logic POL    = 1'b1,
    parameter int   W      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         in_active,
    output logic         sync
);
    // One extra bit so a sync window ending exactly at 2**W still compares correctly
    localparam logic [W:0] LAST     = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_q, cnt_d;
    logic         act_q, act_d;
    logic         sync_q, sync_d;
    logic         at_last;
    logic [W:0]   nxt;

    always_comb begin
        at_last = ({1'b0, cnt_q} == LAST);
        cnt_d   = cnt_q;
        act_d   = act_q;
        sync_d  = sync_q;
        nxt     = '0;
        // Decode the value being loaded so position and flags change on the same edge
        if (en) begin
            cnt_d  = at_last ? '0 : cnt_q + 1'b1;
            nxt    = {1'b0, cnt_d};
            act_d  = (nxt < ACT_END);
            sync_d = (nxt >= SYNC_BEG && nxt < SYNC_END) ? POL : ~POL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= LAST[W-1:0];
            act_q  <= 1'b0;
            sync_q <= ~POL;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            sync_q <= sync_d;
        end
    end

    assign cnt       = cnt_q;
    assign wrap      = en && at_last;
    assign in_active = act_q;
    assign sync      = sync_q;

endmodule

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - pixel raster generator (x/y, active, syncs, strobes); RASTER_LINE_IRQ_EN adds line irq
module raster_counter
    import raster_counter_pkg::*;
#(
    parameter int   H_ACTIVE = P1080_H_ACTIVE,
    parameter int   H_FP     = P1080_H_FP,
    parameter int   H_SYNC   = P1080_H_SYNC,
    parameter int   H_BP     = P1080_H_BP,
    parameter int   V_ACTIVE = P1080_V_ACTIVE,
    parameter int   V_FP     = P1080_V_FP,
    parameter int   V_SYNC   = P1080_V_SYNC,
    parameter int   V_BP     = P1080_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   XW       = 12,
    parameter int   YW       = 11
) (
    input  logic             clk,
    input  logic             reset,
    raster_counter_if.master rif
);
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if ((2 ** XW) < H_TOTAL) begin : g_xw_chk
        $error("raster_counter: XW too narrow for H_TOTAL");
    end
    if ((2 ** YW) < V_TOTAL) begin : g_yw_chk
        $error("raster_counter: YW too narrow for V_TOTAL");
    end
    if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_act_chk
        $error("raster_counter: active size must be non-zero");
    end

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_wrap, v_wrap, v_en;
    logic          h_act, v_act, h_sync, v_sync;

    axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .POL(HS_POL), .W(XW)
    ) u_h (
        .clk(clk), .reset(reset), .en(rif.pix_en),
        .cnt(h_cnt), .wrap(h_wrap), .in_active(h_act), .sync(h_sync)
    );

    // The line counter only moves on the column wrap, so vsync can only change as x becomes 0
    assign v_en = rif.pix_en && h_wrap;

    axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .POL(VS_POL), .W(YW)
    ) u_v (
        .clk(clk), .reset(reset), .en(v_en),
        .cnt(v_cnt), .wrap(v_wrap), .in_active(v_act), .sync(v_sync)
    );

    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    always_comb begin
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef RASTER_LINE_IRQ_EN
    logic          line_irq_q, line_irq_d;
    logic [YW-1:0] y_next;

    always_comb begin
        y_next     = v_wrap ? '0 : v_cnt + 1'b1;
        line_irq_d = h_wrap && (y_next == rif.irq_line);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_irq_q <= 1'b0;
        end else begin
            line_irq_q <= line_irq_d;
        end
    end

    assign rif.line_irq = line_irq_q;
`endif

    assign rif.x           = h_cnt;
    assign rif.y           = v_cnt;
    assign rif.active      = h_act && v_act;
    assign rif.hsync       = h_sync;
    assign rif.vsync       = v_sync;
    assign rif.line_start  = line_start_q;
    assign rif.frame_start = frame_start_q;

endmodule

// File: tb/tb_raster_counter.sv
// tb/tb_raster_counter.sv - scoreboard bench for raster_counter, both sync polarities, small timing
module tb_raster_counter;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int XW = 4, YW = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [YW-1:0] irq_val = 3'd2;

    always #5 clk = ~clk;

    raster_counter_if #(.XW(XW), .YW(YW)) rif_p ();
    raster_counter_if #(.XW(XW), .YW(YW)) rif_n ();

    raster_counter #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .XW(XW), .YW(YW)
    ) u_dut_p (.clk(clk), .reset(reset), .rif(rif_p));

    raster_counter #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .XW(XW), .YW(YW)
    ) u_dut_n (.clk(clk), .reset(reset), .rif(rif_n));

    logic irq_p, irq_n;
`ifdef RASTER_LINE_IRQ_EN
    assign rif_p.irq_line = irq_val;
    assign rif_n.irq_line = irq_val;
    assign irq_p = rif_p.line_irq;
    assign irq_n = rif_n.line_irq;
`else
    assign irq_p = 1'b0;
    assign irq_n = 1'b0;
`endif

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic active, hsync, vsync, line_start, frame_start, line_irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   p = FRAME - 1;
    int   fs_seen = 0;
    int   cyc = 0;
    logic prev_ls = 1'b0;

    function automatic string show(input exp_t v);
        return $sformatf("x=%0d y=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b irq=%0b",
                         v.x, v.y, v.active, v.hsync, v.vsync, v.line_start, v.frame_start, v.line_irq);
    endfunction

    // Reference: one linear pixel index over the frame; x/y and all flags derived arithmetically
    always @(posedge clk) begin : model
        exp_t e;
        int   np, mx, my;
        bit   adv;
        if (reset) begin
            np = FRAME - 1; adv = 1'b0;
        end else if (rif_p.pix_en) begin
            np = (p + 1) % FRAME; adv = 1'b1;
        end else begin
            np = p; adv = 1'b0;
        end
        mx = np % HT;
        my = np / HT;
        e.x           = mx[XW-1:0];
        e.y           = my[YW-1:0];
        e.active      = !reset && (mx < HA) && (my < VA);
        e.hsync       = !reset && (mx >= HA + HF) && (mx < HA + HF + HS);
        e.vsync       = !reset && (my >= VA + VF) && (my < VA + VF + VS);
        e.line_start  = adv && (mx == 0);
        e.frame_start = adv && (np == 0);
`ifdef RASTER_LINE_IRQ_EN
        e.line_irq    = adv && (mx == 0) && (my == int'(irq_val));
`else
        e.line_irq    = 1'b0;
`endif
        exp_q.push_back(e);
        p <= np;
    end

    always @(negedge clk) begin : monitor
        exp_t e, en, gp, gn;
        cyc++;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            gp = {rif_p.x, rif_p.y, rif_p.active, rif_p.hsync, rif_p.vsync,
                  rif_p.line_start, rif_p.frame_start, irq_p};
            gn = {rif_n.x, rif_n.y, rif_n.active, rif_n.hsync, rif_n.vsync,
                  rif_n.line_start, rif_n.frame_start, irq_n};
            en = e;
            en.hsync = ~e.hsync;
            en.vsync = ~e.vsync;
            checks++;
            if (gp !== e) begin
                errors++;
                $display("FAIL raster_pol1 cyc=%0d got %s exp %s", cyc, show(gp), show(e));
            end
            checks++;
            if (gn !== en) begin
                errors++;
                $display("FAIL raster_pol0 cyc=%0d got %s exp %s", cyc, show(gn), show(en));
            end
            if (rif_p.line_start) begin
                checks++;
                if (prev_ls) begin
                    errors++;
                    $display("FAIL line_start_width cyc=%0d got 2-clk pulse exp 1-clk pulse", cyc);
                end
            end
            if (rif_p.frame_start) fs_seen++;
            prev_ls = rif_p.line_start;
        end
    end

    task automatic drive(input logic r, input logic en);
        @(negedge clk);
        #1;
        reset        = r;
        rif_p.pix_en = en;
        rif_n.pix_en = en;
    endtask

    initial begin
        rif_p.pix_en = 1'b0;
        rif_n.pix_en = 1'b0;
        repeat (3) drive(1'b1, 1'b0);

        // Two full frames back to back from reset
        repeat (2 * FRAME) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        @(negedge clk);
        #2;
        checks++;
        if (fs_seen != 2) begin
            errors++;
            $display("FAIL frame_start_count got %0d exp 2", fs_seen);
        end

        // Reset landing mid-frame at (2,1) with pix_en high
        drive(1'b1, 1'b0);
        repeat (HT + 3) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        repeat (30) begin
            drive(1'b0, 1'b1);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b1);
        end

        repeat (900) begin
            if ($urandom_range(0, 49) == 0) irq_val = YW'($urandom_range(0, 7));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));
        end

        drive(1'b0, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp at most 1", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
